scan_mux: RTL and testbench

SCAN_MUX -- requirements
Module: scan_mux

---
 rtl/scan_mux_pkg.sv | 24 ++
 rtl/dwell_counter.sv | 40 ++++
 rtl/scan_mux.sv | 153 +++++++++++++++
 tb/tb_scan_mux.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/scan_mux_pkg.sv
// Shared definitions for the scan_mux block: FSM state encoding, mode
// constants and a constant-evaluable ceil(log2) helper for sizing selects.
package scan_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Smallest r with 2**r >= val; returns 0 for val <= 1.
  function automatic int unsigned clog2(input int unsigned val);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < val) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Dwell counter for scan mode: counts enabled cycles spent on one channel and
// flags the cycle on which the channel must advance.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   i_inc      - count this cycle
//   i_restart  - this cycle is the first of a new dwell (count from zero)
//   i_clr      - drop the count without counting
//   o_tc_c     - combinational terminal count: this counted cycle is DWELL-1
module dwell_counter
  import scan_mux_pkg::*;
#(
  parameter  int unsigned DWELL = 4,
  localparam int unsigned CW    = (clog2(DWELL) < 1) ? 1 : clog2(DWELL)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_restart,
  input  logic i_clr,
  output logic o_tc_c
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_base;

  // A restart counts the current cycle as position zero of the dwell.
  assign w_base = i_restart ? '0 : r_cnt;
  assign o_tc_c = i_inc && (w_base == CW'(DWELL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= o_tc_c ? '0 : (w_base + CW'(1));
    end
  end

endmodule

// File: rtl/scan_mux.sv
// Channel multiplexer with manual selection and automatic round-robin scan.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   din       - N_CH channels of W bits, channel k at [k*W +: W]
//   sel       - manual channel / scan start channel
//   mode      - 0 manual, 1 scan
//   en        - advance enable; everything freezes while low
//   dout      - registered selected data
//   ch_out    - channel dout was taken from
//   valid     - dout/ch_out hold a legal selection
//   wrap      - one-cycle pulse when scan advances from the last channel to 0
//   err       - manual sel is out of range
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter  int unsigned N_CH  = 4,
  parameter  int unsigned W     = 8,
  parameter  int unsigned DWELL = 4,
  localparam int unsigned SW    = (clog2(N_CH) < 1) ? 1 : clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] din,
  input  logic [SW-1:0]     sel,
  input  logic              mode,
  input  logic              en,
  output logic [W-1:0]      dout,
  output logic [SW-1:0]     ch_out,
  output logic              valid,
  output logic              wrap,
  output logic              err
);

  state_t          r_state;
  logic [W-1:0]    r_dout;
  logic [SW-1:0]   r_ch_out;
  logic            r_valid;
  logic            r_wrap;
  logic            r_err;
  logic [SW-1:0]   r_cur;

  state_t          w_state_nxt;
  logic [W-1:0]    w_dout_nxt;
  logic [SW-1:0]   w_ch_nxt;
  logic            w_valid_nxt;
  logic            w_wrap_nxt;
  logic            w_err_nxt;
  logic [SW-1:0]   w_cur_nxt;

  logic            w_sel_ok;
  logic [SW-1:0]   w_sel_idx;
  logic            w_scan_entry;
  logic [SW-1:0]   w_cur_eff;
  logic [SW-1:0]   w_mux_idx;
  logic [W-1:0]    w_mux_data;
  logic            w_last;
  logic [SW-1:0]   w_cur_inc;
  logic            w_tc;

  assign w_sel_ok  = (32'(sel) < N_CH);
  assign w_sel_idx = w_sel_ok ? sel : '0;

  // Entering scan from idle or manual starts at sel (or 0 if out of range).
  assign w_scan_entry = en && (mode == MODE_SCAN) && (r_state != ST_SCAN);
  assign w_cur_eff    = w_scan_entry ? w_sel_idx : r_cur;

  // One shared part-select serves both modes.
  assign w_mux_idx  = (mode == MODE_SCAN) ? w_cur_eff : w_sel_idx;
  assign w_mux_data = din[32'(w_mux_idx) * W +: W];

  // Explicit wrap keeps cur below N_CH when N_CH is not a power of two.
  assign w_last    = (32'(w_cur_eff) == (N_CH - 1));
  assign w_cur_inc = w_last ? '0 : (w_cur_eff + SW'(1));

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk       (clk),
    .rst       (rst),
    .i_inc     (en && (mode == MODE_SCAN)),
    .i_restart (w_scan_entry),
    .i_clr     (en && (mode == MODE_MANUAL)),
    .o_tc_c    (w_tc)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_dout   <= '0;
      r_ch_out <= '0;
      r_valid  <= 1'b0;
      r_wrap   <= 1'b0;
      r_err    <= 1'b0;
      r_cur    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_dout   <= w_dout_nxt;
      r_ch_out <= w_ch_nxt;
      r_valid  <= w_valid_nxt;
      r_wrap   <= w_wrap_nxt;
      r_err    <= w_err_nxt;
      r_cur    <= w_cur_nxt;
    end
  end

  // Next state and next outputs; every state exits by mode on an en cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_dout_nxt  = r_dout;
    w_ch_nxt    = r_ch_out;
    w_valid_nxt = r_valid;
    w_err_nxt   = r_err;
    w_wrap_nxt  = 1'b0;
    w_cur_nxt   = r_cur;

    if (en) begin
      if (mode == MODE_SCAN) begin
        w_state_nxt = ST_SCAN;
        w_dout_nxt  = w_mux_data;
        w_ch_nxt    = w_cur_eff;
        w_valid_nxt = 1'b1;
        w_err_nxt   = 1'b0;
        if (w_tc) begin
          w_cur_nxt  = w_cur_inc;
          w_wrap_nxt = w_last;
        end else begin
          w_cur_nxt  = w_cur_eff;
        end
      end else begin
        w_state_nxt = ST_MANUAL;
        if (w_sel_ok) begin
          w_dout_nxt  = w_mux_data;
          w_ch_nxt    = sel;
          w_valid_nxt = 1'b1;
          w_err_nxt   = 1'b0;
        end else begin
          w_dout_nxt  = '0;
          w_ch_nxt    = '0;
          w_valid_nxt = 1'b0;
          w_err_nxt   = 1'b1;
        end
      end
    end
  end

  assign dout   = r_dout;
  assign ch_out = r_ch_out;
  assign valid  = r_valid;
  assign wrap   = r_wrap;
  assign err    = r_err;

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: instance a (N_CH=4, DWELL=4) and instance b
// (N_CH=3, DWELL=1), a per-cycle reference model and directed checks.
module tb_scan_mux;

  logic        clk;
  logic        rst_a, en_a, mode_a;
  logic [1:0]  sel_a;
  logic [31:0] din_a;
  logic [7:0]  dout_a;
  logic [1:0]  ch_a;
  logic        valid_a, wrap_a, err_a;

  logic        rst_b, en_b, mode_b;
  logic [1:0]  sel_b;
  logic [23:0] din_b;
  logic [7:0]  dout_b;
  logic [1:0]  ch_b;
  logic        valid_b, wrap_b, err_b;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 0;

  scan_mux #(.N_CH(4), .W(8), .DWELL(4)) dut_a (
    .clk(clk), .rst(rst_a), .din(din_a), .sel(sel_a), .mode(mode_a), .en(en_a),
    .dout(dout_a), .ch_out(ch_a), .valid(valid_a), .wrap(wrap_a), .err(err_a)
  );

  scan_mux #(.N_CH(3), .W(8), .DWELL(1)) dut_b (
    .clk(clk), .rst(rst_b), .din(din_b), .sel(sel_b), .mode(mode_b), .en(en_b),
    .dout(dout_b), .ch_out(ch_b), .valid(valid_b), .wrap(wrap_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: scan position is (start + k/DWELL) mod N_CH, k = en cycles since scan entry.
  int         NCH[2] = '{4, 3};
  int         DW[2]  = '{4, 1};
  bit         m_scan[2];
  int         m_start[2];
  int         m_k[2];
  logic [7:0] e_dout[2];
  int         e_ch[2];
  bit         e_valid[2], e_wrap[2], e_err[2];

  task automatic model_step(input int i, input bit r, input bit e, input bit m,
                            input int s, input logic [127:0] d);
    e_wrap[i] = 1'b0;
    if (r) begin
      m_scan[i] = 0; m_start[i] = 0; m_k[i] = 0;
      e_dout[i] = 8'h00; e_ch[i] = 0; e_valid[i] = 0; e_err[i] = 0;
    end else if (e) begin
      if (m) begin
        if (!m_scan[i]) begin
          m_start[i] = (s < NCH[i]) ? s : 0;
          m_k[i] = 0;
          m_scan[i] = 1;
        end
        e_ch[i]    = (m_start[i] + m_k[i] / DW[i]) % NCH[i];
        e_dout[i]  = d[e_ch[i]*8 +: 8];
        e_valid[i] = 1; e_err[i] = 0;
        e_wrap[i]  = ((m_k[i] % DW[i]) == DW[i] - 1) && (e_ch[i] == NCH[i] - 1);
        m_k[i]     = m_k[i] + 1;
      end else begin
        m_scan[i] = 0;
        if (s < NCH[i]) begin
          e_dout[i] = d[s*8 +: 8]; e_ch[i] = s; e_valid[i] = 1; e_err[i] = 0;
        end else begin
          e_dout[i] = 8'h00; e_ch[i] = 0; e_valid[i] = 0; e_err[i] = 1;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst_a, en_a, mode_a, int'(sel_a), 128'(din_a));
    model_step(1, rst_b, en_b, mode_b, int'(sel_b), 128'(din_b));
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Every cycle: both DUTs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("a.dout",  32'(dout_a),  32'(e_dout[0]));
      chk("a.ch",    32'(ch_a),    32'(e_ch[0]));
      chk("a.valid", 32'(valid_a), 32'(e_valid[0]));
      chk("a.wrap",  32'(wrap_a),  32'(e_wrap[0]));
      chk("a.err",   32'(err_a),   32'(e_err[0]));
      chk("b.dout",  32'(dout_b),  32'(e_dout[1]));
      chk("b.ch",    32'(ch_b),    32'(e_ch[1]));
      chk("b.valid", 32'(valid_b), 32'(e_valid[1]));
      chk("b.wrap",  32'(wrap_b),  32'(e_wrap[1]));
      chk("b.err",   32'(err_b),   32'(e_err[1]));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] exp_man[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int         exp_ch[20] = '{2,2,2,2, 3,3,3,3, 0,0,0,0, 1,1,1,1, 2,2,2,2};
  int         exp_b[4]   = '{0, 1, 2, 0};

  initial begin
    rst_a = 1; en_a = 0; mode_a = 0; sel_a = 2'd0; din_a = 32'h44332211;
    rst_b = 1; en_b = 0; mode_b = 0; sel_b = 2'd0; din_b = 24'hCCBBAA;
    tick(2);
    chk_on = 1;
    chk("rst.a.dout",  32'(dout_a),  32'h0);
    chk("rst.a.valid", 32'(valid_a), 32'h0);
    chk("rst.b.err",   32'(err_b),   32'h0);
    rst_a = 0; rst_b = 0;

    // Illegal then legal manual select on the 3-channel instance.
    en_b = 1; mode_b = 0; sel_b = 2'd3;
    tick();
    chk("ill.b.err",   32'(err_b),   32'h1);
    chk("ill.b.valid", 32'(valid_b), 32'h0);
    chk("ill.b.dout",  32'(dout_b),  32'h0);
    chk("ill.model.err", 32'(e_err[1]), 32'h1);
    sel_b = 2'd1;
    tick();
    chk("leg.b.err",  32'(err_b),  32'h0);
    chk("leg.b.dout", 32'(dout_b), 32'hBB);

    // DWELL=1 scan from an out-of-range sel starts at 0, advances every cycle.
    mode_b = 1; sel_b = 2'd3;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("b.scan.ch",   32'(ch_b),   32'(exp_b[j]));
      chk("b.scan.wrap", 32'(wrap_b), 32'(j == 2));
    end

    // Manual sweep.
    en_a = 1; mode_a = 0;
    for (int s = 0; s < 4; s++) begin
      sel_a = 2'(s);
      tick();
      chk("man.dout",  32'(dout_a),  32'(exp_man[s]));
      chk("man.valid", 32'(valid_a), 32'h1);
    end

    // Scan from channel 2, 20 enabled cycles.
    mode_a = 1; sel_a = 2'd2;
    for (int j = 0; j < 20; j++) begin
      tick();
      chk("scan.ch",   32'(ch_a),   32'(exp_ch[j]));
      chk("scan.wrap", 32'(wrap_a), 32'(j == 7));
      if (j == 7) chk("scan.model.wrap", 32'(e_wrap[0]), 32'h1);
    end

    // Freeze at channel 3, dwell 2.
    tick(2);
    en_a = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("frz.ch",   32'(ch_a),   32'h3);
      chk("frz.wrap", 32'(wrap_a), 32'h0);
      chk("frz.dout", 32'(dout_a), 32'h44);
    end
    en_a = 1;
    tick();
    chk("res1.ch",   32'(ch_a),   32'h3);
    chk("res1.wrap", 32'(wrap_a), 32'h0);
    tick();
    chk("res2.ch",   32'(ch_a),   32'h3);
    chk("res2.wrap", 32'(wrap_a), 32'h1);
    tick();
    chk("res3.ch",   32'(ch_a),   32'h0);
    chk("res3.dout", 32'(dout_a), 32'h11);

    // Advance to channel 3 / dwell 1, then reset with en and mode still high.
    tick(12);
    chk("pre_rst.ch", 32'(ch_a), 32'h3);
    rst_a = 1;
    tick();
    chk("mrst.dout",  32'(dout_a),  32'h0);
    chk("mrst.valid", 32'(valid_a), 32'h0);
    chk("mrst.ch",    32'(ch_a),    32'h0);
    rst_a = 0; sel_a = 2'd0;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("rs.ch0", 32'(ch_a), 32'h0);
    end
    tick();
    chk("rs.ch1",   32'(ch_a),   32'h1);
    chk("rs.dout1", 32'(dout_a), 32'h22);

    // Mode toggle: scan on ch 1 -> manual sel 3 -> scan restarts at 3.
    mode_a = 0; sel_a = 2'd3;
    tick();
    chk("tog.ch",    32'(ch_a),    32'h3);
    chk("tog.dout",  32'(dout_a),  32'h44);
    mode_a = 1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("tog.scan.ch",   32'(ch_a),   32'h3);
      chk("tog.scan.wrap", 32'(wrap_a), 32'(j == 3));
    end
    tick();
    chk("tog.after.ch", 32'(ch_a), 32'h0);

    // Mixed directed tail, checked by the model only.
    en_a = 0; mode_a = 0; tick();
    en_a = 1; tick();
    sel_a = 2'd1; din_a = 32'hA5C3_0F96; tick();
    mode_a = 1; tick(3);
    en_b = 0; tick(2);
    en_b = 1; mode_b = 0; sel_b = 2'd2; tick();
    rst_b = 1; tick();
    rst_b = 0; mode_b = 1; sel_b = 2'd1; tick(5);

    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
